// File: rtl/serdes_pkg.sv
// Shared SERDES link definitions: transmit FSM states and line levels.
// The receiver will import the same levels so both ends agree on framing.
package serdes_pkg;

    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/axis_serial_tx_if.sv
// FIFO read port seen by the serializer: request out, empty flag and read data in.
interface axis_serial_tx_if #(
    parameter int unsigned DATA_W = 32
);

    logic              rr;
    logic              rempty;
    logic [DATA_W-1:0] rdata;

    // Reader side (the serializer issues the read request).
    modport master (
        output rr,
        input  rempty,
        input  rdata
    );

    // FIFO side (answers with a registered read).
    modport slave (
        input  rr,
        output rempty,
        output rdata
    );

endinterface

// File: rtl/axis_serial_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// o_tick is registered; o_pre_tick_c tells the caller the next cycle is a tick cycle,
// so registered outputs that must line up with the tick can be computed one cycle early.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic ref_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick,
    output logic o_pre_tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count: wrap at the bit boundary, restart on a clear.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        if (i_clr || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == CNT_MAX);
    end

    // Counter and tick registers.
    always_ff @(posedge ref_clk) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick       = tick_q;
    assign o_pre_tick_c = tick_d;

endmodule

// File: rtl/axis_serial_tx.sv
// Transmit serializer: pulls one word per frame from the FIFO read port and sends
// start(0), DATA_W bits LSB first, optional even parity, stop(1). Line idles high.
module axis_serial_tx
    import serdes_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic             ref_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    axis_serial_tx_if.master fifo_if,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_frame_done
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              rr_q, rr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              baud_clr_c;
    logic              tick;
    logic              pre_tick_c;

    // Bit periods are aligned to the start bit: the timer restarts as START is entered.
    assign baud_clr_c = (state_q == LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .ref_clk      (ref_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (baud_clr_c),
        .o_tick       (tick),
        .o_pre_tick_c (pre_tick_c)
    );

    // Next state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = IDLE_LEVEL;
        rr_d      = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_en && !fifo_if.rempty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = fifo_if.rdata;
                par_d   = ^fifo_if.rdata;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they change on the same edge.
        unique case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase
        rr_d   = (state_d == FETCH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && pre_tick_c;
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge ref_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LEVEL;
            rr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign fifo_if.rr   = rr_q;
    assign o_tx         = tx_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_axis_serial_tx.sv
// Bench for axis_serial_tx: FIFO model with registered read, mid-bit sampling receiver,
// directed scenarios with random payloads. Two instances cover both parameter sets.
module tb_axis_serial_tx;

    logic ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    logic i_rst_n;
    logic en_a, en_b, sel;
    logic tx_a, busy_a, fd_a;
    logic tx_b, busy_b, fd_b;

    int checks   = 0;
    int failures = 0;

    axis_serial_tx_if #(.DATA_W(32)) if_a ();
    axis_serial_tx_if #(.DATA_W(32)) if_b ();

    axis_serial_tx #(.DATA_W(32), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut_a (
        .ref_clk      (ref_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (en_a),
        .fifo_if      (if_a),
        .o_tx         (tx_a),
        .o_busy       (busy_a),
        .o_frame_done (fd_a)
    );

    axis_serial_tx #(.DATA_W(32), .CLKS_PER_BIT(2), .PARITY_EN(1'b0)) u_dut_b (
        .ref_clk      (ref_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (en_b),
        .fifo_if      (if_b),
        .o_tx         (tx_b),
        .o_busy       (busy_b),
        .o_frame_done (fd_b)
    );

    // FIFO model: one word store shared by whichever instance is selected.
    logic [31:0] mem [0:255];
    int          push_n = 0;
    int          pop_n = 0;
    int          underflow_n = 0;
    logic [31:0] fifo_rdata = '0;
    logic        fifo_empty, fifo_pop;
    int          cyc = 0;

    assign fifo_empty  = (push_n == pop_n);
    assign fifo_pop    = sel ? if_b.rr : if_a.rr;
    assign if_a.rempty = sel ? 1'b1 : fifo_empty;
    assign if_b.rempty = sel ? fifo_empty : 1'b1;
    assign if_a.rdata  = fifo_rdata;
    assign if_b.rdata  = fifo_rdata;

    always @(posedge ref_clk) begin
        cyc <= cyc + 1;
        if (fifo_pop === 1'b1) begin
            if (push_n == pop_n) begin
                underflow_n <= underflow_n + 1;
            end else begin
                fifo_rdata <= mem[pop_n[7:0]];
                pop_n      <= pop_n + 1;
            end
        end
    end

    logic mon_tx, mon_fd, mon_rr, mon_rempty;
    assign mon_tx     = sel ? tx_b : tx_a;
    assign mon_fd     = sel ? fd_b : fd_a;
    assign mon_rr     = sel ? if_b.rr : if_a.rr;
    assign mon_rempty = sel ? if_b.rempty : if_a.rempty;

    int rr_cnt = 0;
    int rr_empty_n = 0;
    always @(negedge ref_clk) begin
        if (mon_rr === 1'b1) rr_cnt++;
        if (mon_rr === 1'b1 && mon_rempty === 1'b1) rr_empty_n++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver model: frames found by a falling edge on an idle line, sampled mid-bit.
    logic [31:0] rx_data_q[$];
    int          rx_start_q[$];
    int          rx_len_q[$];
    logic        rx_par_q[$];
    bit          rx_busy = 1'b0;
    int          rx_live_start = 0;

    task automatic rx_frame();
        int          cpb;
        int          nb;
        int          total;
        bit          pe;
        logic [63:0] bits;
        logic [31:0] data;
        int          done_cnt;
        int          done_off;
        logic        idle_after;
        bit          aborted;
        int          start;
        cpb        = sel ? 2 : 4;
        pe         = !sel;
        nb         = 34 + int'(pe);
        total      = nb * cpb;
        bits       = '0;
        done_cnt   = 0;
        done_off   = -1;
        idle_after = 1'bx;
        aborted    = 1'b0;
        start      = cyc;
        rx_busy       = 1'b1;
        rx_live_start = start;
        for (int off = 0; off <= total; off++) begin
            if (off > 0) @(negedge ref_clk);
            if (i_rst_n !== 1'b1) begin
                aborted = 1'b1;
                break;
            end
            if (off < total) begin
                if (off % cpb == cpb / 2) bits[off / cpb] = mon_tx;
                if (mon_fd === 1'b1) begin
                    done_cnt++;
                    done_off = off;
                end
            end else begin
                idle_after = mon_tx;
            end
        end
        rx_busy = 1'b0;
        if (!aborted) begin
            data = bits[32:1];
            chk("rx_start_bit", 64'(bits[0]), 64'(1'b0));
            chk("rx_stop_bit", 64'(bits[nb-1]), 64'(1'b1));
            if (pe) chk("rx_even_parity", 64'(($countones(data) + int'(bits[33])) % 2), 64'(0));
            chk("rx_done_pulses", 64'(done_cnt), 64'(1));
            chk("rx_done_last_cycle", 64'(done_off), 64'(total - 1));
            chk("rx_idle_after_stop", 64'(idle_after), 64'(1'b1));
            rx_data_q.push_back(data);
            rx_start_q.push_back(start);
            rx_len_q.push_back(done_off + 1);
            rx_par_q.push_back(bits[33]);
        end
    endtask

    initial begin
        forever begin
            @(negedge ref_clk);
            if (i_rst_n === 1'b1 && mon_tx === 1'b0) rx_frame();
        end
    end

    // Helpers for the directed sequence.
    task automatic tick(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[push_n[7:0]] = w;
        push_n = push_n + 1;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_data_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (rx_data_q.size() < n) chk(tag, 64'(rx_data_q.size()), 64'(n));
    endtask

    task automatic wait_rr(input int n, input int budget, input string tag);
        int k = 0;
        while (rr_cnt < n && k < budget) begin
            tick(1);
            k++;
        end
        if (rr_cnt < n) chk(tag, 64'(rr_cnt), 64'(n));
    endtask

    function automatic logic exp_par(input logic [31:0] w);
        return logic'($countones(w) % 2);
    endfunction

    logic [31:0] words[8];
    int          r0, rr0, base, s, bad, k;

    initial begin
        i_rst_n = 1'b0;
        en_a    = 1'b0;
        en_b    = 1'b0;
        sel     = 1'b0;

        // 1: reset values, then an empty FIFO must never be read
        tick(2);
        chk("rst_tx", 64'(tx_a), 64'(1'b1));
        chk("rst_rr", 64'(if_a.rr), 64'(1'b0));
        chk("rst_busy", 64'(busy_a), 64'(1'b0));
        chk("rst_done", 64'(fd_a), 64'(1'b0));
        chk("rst_tx_b", 64'(tx_b), 64'(1'b1));
        chk("rst_busy_b", 64'(busy_b), 64'(1'b0));
        i_rst_n = 1'b1;
        en_a    = 1'b1;
        bad     = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (tx_a !== 1'b1 || if_a.rr !== 1'b0) bad++;
        end
        chk("empty_hold_idle", 64'(bad), 64'(0));
        chk("empty_no_rr", 64'(rr_cnt), 64'(0));

        // 2: single known word, latency and frame length
        r0   = rx_data_q.size();
        rr0  = rr_cnt;
        base = cyc;
        push_word(32'hA5A5_0F01);
        wait_rx(r0 + 1, 300, "single_timeout");
        if (rx_data_q.size() > r0) begin
            chk("single_data", 64'(rx_data_q[r0]), 64'(32'hA5A5_0F01));
            chk("single_parity", 64'(rx_par_q[r0]), 64'(exp_par(32'hA5A5_0F01)));
            chk("single_latency", 64'(rx_start_q[r0] - base), 64'(3));
            chk("single_len", 64'(rx_len_q[r0]), 64'((32 + 2 + 1) * 4));
        end
        chk("single_rr", 64'(rr_cnt - rr0), 64'(1));

        // 3: burst of random words, in order, fixed inter-frame spacing
        tick(3);
        r0  = rx_data_q.size();
        rr0 = rr_cnt;
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom;
            push_word(words[i]);
        end
        wait_rx(r0 + 8, 8 * 150 + 100, "burst_timeout");
        for (int i = 0; i < 8; i++) begin
            if (rx_data_q.size() > r0 + i) begin
                chk($sformatf("burst_data%0d", i), 64'(rx_data_q[r0+i]), 64'(words[i]));
                chk($sformatf("burst_par%0d", i), 64'(rx_par_q[r0+i]), 64'(exp_par(words[i])));
                if (i > 0) chk($sformatf("burst_gap%0d", i),
                               64'(rx_start_q[r0+i] - rx_start_q[r0+i-1]), 64'(140 + 3));
            end
        end
        chk("burst_rr", 64'(rr_cnt - rr0), 64'(8));
        tick(2);
        chk("burst_idle_busy", 64'(busy_a), 64'(1'b0));

        // 4: enable dropped during word 2's data phase
        r0  = rx_data_q.size();
        rr0 = rr_cnt;
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom;
            push_word(words[i]);
        end
        wait_rr(rr0 + 2, 400, "en_rr_timeout");
        tick(60);
        chk("en_drop_busy_mid", 64'(busy_a), 64'(1'b1));
        en_a = 1'b0;
        wait_rx(r0 + 2, 300, "en_word2_timeout");
        tick(50);
        chk("en_hold_rr", 64'(rr_cnt - rr0), 64'(2));
        chk("en_hold_frames", 64'(rx_data_q.size() - r0), 64'(2));
        chk("en_hold_busy", 64'(busy_a), 64'(1'b0));
        chk("en_hold_tx", 64'(tx_a), 64'(1'b1));
        en_a = 1'b1;
        wait_rx(r0 + 4, 400, "en_resume_timeout");
        for (int i = 0; i < 4; i++) begin
            if (rx_data_q.size() > r0 + i)
                chk($sformatf("en_data%0d", i), 64'(rx_data_q[r0+i]), 64'(words[i]));
        end
        chk("en_total_rr", 64'(rr_cnt - rr0), 64'(4));

        // 5: reset pulse at data bit 10 drops the word in flight only
        tick(5);
        r0  = rx_data_q.size();
        rr0 = rr_cnt;
        words[0] = $urandom;
        words[1] = $urandom;
        push_word(words[0]);
        push_word(words[1]);
        k = 0;
        while (!rx_busy && k < 50) begin
            tick(1);
            k++;
        end
        chk("rst_mid_frame_started", 64'(rx_busy), 64'(1'b1));
        s = rx_live_start;
        k = 0;
        while (cyc < s + 4 + 10 * 4 + 1 && k < 100) begin
            tick(1);
            k++;
        end
        i_rst_n = 1'b0;
        tick(1);
        chk("rst_mid_tx", 64'(tx_a), 64'(1'b1));
        chk("rst_mid_busy", 64'(busy_a), 64'(1'b0));
        chk("rst_mid_rr", 64'(if_a.rr), 64'(1'b0));
        i_rst_n = 1'b1;
        wait_rx(r0 + 1, 300, "rst_next_timeout");
        if (rx_data_q.size() > r0)
            chk("rst_next_word", 64'(rx_data_q[r0]), 64'(words[1]));
        tick(20);
        chk("rst_frames", 64'(rx_data_q.size() - r0), 64'(1));
        chk("rst_rr", 64'(rr_cnt - rr0), 64'(2));

        // 6: no parity, two clocks per bit, all-ones word
        en_a = 1'b0;
        tick(2);
        sel  = 1'b1;
        en_b = 1'b1;
        tick(1);
        r0   = rx_data_q.size();
        rr0  = rr_cnt;
        base = cyc;
        push_word(32'hFFFF_FFFF);
        wait_rx(r0 + 1, 200, "nopar_timeout");
        if (rx_data_q.size() > r0) begin
            chk("nopar_data", 64'(rx_data_q[r0]), 64'(32'hFFFF_FFFF));
            chk("nopar_len", 64'(rx_len_q[r0]), 64'((32 + 2) * 2));
            chk("nopar_latency", 64'(rx_start_q[r0] - base), 64'(3));
        end
        chk("nopar_rr", 64'(rr_cnt - rr0), 64'(1));
        tick(5);
        chk("nopar_idle_tx", 64'(tx_b), 64'(1'b1));
        chk("nopar_idle_busy", 64'(busy_b), 64'(1'b0));

        // Global FIFO protocol
        chk("fifo_underflow", 64'(underflow_n), 64'(0));
        chk("rr_while_empty", 64'(rr_empty_n), 64'(0));
        chk("fifo_drained", 64'(push_n - pop_n), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
